// File: rtl/fm_decimator.sv
// rtl/fm_decimator.sv - accumulate-and-dump decimating averager for FM phase-difference samples
module fm_decimator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DECIM_LOG2             = 4
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);

    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
    localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) << (DECIM_LOG2 - 1);

    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [DECIM_LOG2-1:0]        cnt_q, cnt_d;
    logic [15:0]                  tdata_q, tdata_d;
    logic                         tvalid_q, tvalid_d;
    logic                         tlast_q, tlast_d;
    logic                         accept, dump;
    logic signed [SUM_W-1:0]      x_ext, sum, rounded, shifted;
    logic                         unused_bits;

    // A stalled full output register blocks every input, not only dumping ones.
    assign s00_axis_tready = ~s00_axis_aresetn && (~tvalid_q || m00_axis_tready);
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign dump            = accept && ((cnt_q == CNT_LAST) || s00_axis_tlast);

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    assign x_ext   = {{(SUM_W-16){s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};
    assign sum     = {acc_q[ACC_W-1], acc_q} + x_ext;
    assign rounded = sum + ROUND;
    assign shifted = rounded >>> DECIM_LOG2;

    assign unused_bits = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16], s00_axis_tstrb,
                           shifted[SUM_W-1:16]};

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (accept) begin
            if (dump) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A dump in the same cycle as a drain simply replaces the value, no bubble.
        if (dump) begin
            tdata_d  = shifted[15:0];
            tvalid_d = 1'b1;
            tlast_d  = s00_axis_tlast;
        end else if (tvalid_q && m00_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_aresetn) begin
        if (s00_axis_aresetn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-16){tdata_q[15]}}, tdata_q};
    assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_decimator.sv
// tb/tb_fm_decimator.sv - randomized self-checking bench for fm_decimator (N=4 and N=16 instances)
module tb_fm_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid[2], s_tready[2], s_tlast[2];
    logic        m_tready[2], m_tvalid[2], m_tlast[2];
    logic [31:0] s_tdata[2], m_tdata[2];
    logic [3:0]  s_tstrb[2], m_tstrb[2];

    int          tests = 0;
    int          fails = 0;
    int          cur = 0;
    int          bp_pct = 0;
    int          mx[$];
    bit          ml[$];
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    always #5 clk = ~clk;

    fm_decimator #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .DECIM_LOG2(2)) u_d2 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst),
        .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tready(s_tready[0]),
        .s00_axis_tdata(s_tdata[0]), .s00_axis_tstrb(s_tstrb[0]), .s00_axis_tlast(s_tlast[0]),
        .m00_axis_tready(m_tready[0]), .m00_axis_tvalid(m_tvalid[0]),
        .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]), .m00_axis_tlast(m_tlast[0])
    );

    fm_decimator #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .DECIM_LOG2(4)) u_d4 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst),
        .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tready(s_tready[1]),
        .s00_axis_tdata(s_tdata[1]), .s00_axis_tstrb(s_tstrb[1]), .s00_axis_tlast(s_tlast[1]),
        .m00_axis_tready(m_tready[1]), .m00_axis_tvalid(m_tvalid[1]),
        .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]), .m00_axis_tlast(m_tlast[1])
    );

    // Record every completed output handshake of the instance under test.
    always @(negedge clk) begin
        #4;
        if (m_tvalid[cur] === 1'b1 && m_tready[cur] === 1'b1)
            got_q.push_back({m_tlast[cur], m_tdata[cur]});
    end

    // Reference: mean of each window (closed at N samples or tlast), always divided by N,
    // rounded half toward +inf: floor((sum + N/2) / N).
    function automatic void build_expected(input int l2);
        int n, sum, cnt, num, y;
        n = 1 << l2;
        sum = 0;
        cnt = 0;
        exp_q.delete();
        foreach (mx[i]) begin
            sum += mx[i];
            cnt++;
            if (cnt == n || ml[i]) begin
                num = sum + n / 2;
                y = (num >= 0) ? num / n : -((-num + n - 1) / n);
                exp_q.push_back({ml[i], 32'(y)});
                sum = 0;
                cnt = 0;
            end
        end
    endfunction

    task automatic begin_test(input int idx);
        cur = idx;
        bp_pct = 0;
        mx.delete();
        ml.delete();
        got_q.delete();
        m_tready[idx] = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        bit ok = 0;
        mx.push_back(int'($signed(d)));
        ml.push_back(last);
        for (int c = 0; c < 200 && !ok; c++) begin
            if (bp_pct > 0) m_tready[cur] = ($urandom_range(99) >= bp_pct);
            s_tvalid[cur] = 1'b1;
            s_tdata[cur]  = {16'($urandom), d};
            s_tstrb[cur]  = 4'($urandom);
            s_tlast[cur]  = last;
            #4;
            ok = (s_tready[cur] === 1'b1);
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_accept: sample %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic drain();
        s_tvalid[cur] = 1'b0;
        s_tlast[cur]  = 1'b0;
        bp_pct = 0;
        m_tready[cur] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tests += 5;
            if (s_tready[i] !== 1'b0) begin fails++; $display("FAIL reset_s_tready[%0d]: got %b want 0", i, s_tready[i]); end
            if (m_tvalid[i] !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid[%0d]: got %b want 0", i, m_tvalid[i]); end
            if (m_tdata[i] !== 32'h0) begin fails++; $display("FAIL reset_m_tdata[%0d]: got %h want 0", i, m_tdata[i]); end
            if (m_tlast[i] !== 1'b0) begin fails++; $display("FAIL reset_m_tlast[%0d]: got %b want 0", i, m_tlast[i]); end
            if (m_tstrb[i] !== 4'hF) begin fails++; $display("FAIL reset_m_tstrb[%0d]: got %h want f", i, m_tstrb[i]); end
        end
    endtask

    task automatic test_basic();
        begin_test(0);
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
        s_tvalid[0] = 1'b0;
        tests++;
        if (m_tvalid[0] !== 1'b1) begin fails++; $display("FAIL basic_tvalid_rise: got %b want 1", m_tvalid[0]); end
        @(negedge clk);
        tests++;
        if (m_tvalid[0] !== 1'b0) begin fails++; $display("FAIL basic_tvalid_fall: got %b want 0", m_tvalid[0]); end
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_negative();
        begin_test(0);
        send(16'hFFFF, 0); send(16'hFFFF, 0); send(16'hFFFF, 0); send(16'hFFFE, 0);
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL neg_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL neg_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_tlast();
        begin_test(0);
        send(16'd8, 0); send(16'd8, 1);
        repeat (4) send(16'd4, 0);
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL tlast_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL tlast_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] held;
        begin_test(0);
        m_tready[0] = 1'b0;
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
        build_expected(2);
        held = exp_q[0];
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 32'h0000_0009;
        s_tlast[0]  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            tests += 3;
            if (s_tready[0] !== 1'b0) begin fails++; $display("FAIL bp_s_tready cyc %0d: got %b want 0", c, s_tready[0]); end
            if (m_tvalid[0] !== 1'b1) begin fails++; $display("FAIL bp_m_tvalid cyc %0d: got %b want 1", c, m_tvalid[0]); end
            if ({m_tlast[0], m_tdata[0]} !== held) begin
                fails++; $display("FAIL bp_hold cyc %0d: got %h want %h", c, {m_tlast[0], m_tdata[0]}, held);
            end
            @(negedge clk);
        end
        m_tready[0] = 1'b1;
        send(16'd9, 0); send(16'd10, 0); send(16'd11, 0); send(16'd12, 0);
        bp_pct = 50;
        for (int k = 0; k < 40; k++)
            send(16'($urandom), (k == 39) || ($urandom_range(9) == 0));
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_scale();
        begin_test(1);
        repeat (16) send(16'h7FFF, 0);
        repeat (16) send(16'h8000, 0);
        bp_pct = 30;
        for (int k = 0; k < 48; k++)
            send(16'($urandom), (k == 47) || ($urandom_range(19) == 0));
        drain();
        build_expected(4);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL full_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_window();
        begin_test(0);
        m_tready[0] = 1'b0;
        repeat (4) send(16'd7, 0);
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            fails++; $display("FAIL rst_pre_out: got %0d items first %h want %h", got_q.size(), got_q[0], exp_q[0]);
        end
        send(16'd100, 0); send(16'd100, 0);
        s_tvalid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests += 4;
        if (m_tdata[0] !== 32'h0) begin fails++; $display("FAIL rst_mid_tdata: got %h want 0", m_tdata[0]); end
        if (m_tvalid[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_tvalid: got %b want 0", m_tvalid[0]); end
        if (m_tlast[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_tlast: got %b want 0", m_tlast[0]); end
        if (s_tready[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_s_tready: got %b want 0", s_tready[0]); end
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        begin_test(0);
        repeat (4) send(16'd5, 0);
        drain();
        build_expected(2);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_post_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_post_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[i]  = 32'h0;
            s_tstrb[i]  = 4'h0;
            m_tready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_negative();
        test_tlast();
        test_backpressure();
        test_full_scale();
        test_reset_mid_window();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fm_decimator.md
# fm_decimator

Accumulate-and-dump decimating low-pass stage that sits directly downstream of the FM phase-difference demodulator. It consumes one signed 16-bit phase-difference sample per AXI-Stream beat and averages 2^DECIM_LOG2 consecutive samples with rounding. It emits one averaged sample per window on an AXI-Stream master toward the audio path. Input tlast closes the current window early and is propagated.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32: input stream width; only [15:0] is used.
- C_M00_AXIS_TDATA_WIDTH, 32: output stream width.
- DECIM_LOG2, 4: log2 of the decimation factor N; legal range 1..8 (N = 2..256).
- s00_axis_aclk  in  1  sole clock; all state on its rising edge.
- s00_axis_aresetn  in  1  asynchronous, active-high reset; the block is in reset while this is 1.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tready  out  1  input accept.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  [15:0] signed phase difference; [31:16] ignored.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tlast  in  1  end of record; forces a window dump.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tvalid  out  1  output sample valid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  [15:0] signed average, sign-extended into [31:16].
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones.
- m00_axis_tlast  out  1  set on the output that closes a tlast-terminated window.

## Operation
- State:
  - acc: signed accumulator, 16+DECIM_LOG2 bits.
  - cnt: DECIM_LOG2-bit sample counter.
  - Output register: tdata, tvalid, tlast.
- Accept condition: s00_axis_tvalid && s00_axis_tready. x = $signed(s00_axis_tdata[15:0]).
- Non-dump accept (cnt != N-1 and tlast = 0):
  - acc <= acc + x; cnt <= cnt + 1.
  - Output register unchanged.
- Dump accept (cnt == N-1, or s00_axis_tlast = 1):
  - sum = acc + x.
  - y = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2. Rounds half toward +inf. A full window always fits in 16 bits; no saturation is needed.
  - m00_axis_tdata <= sign-extended y[15:0]; m00_axis_tvalid <= 1; m00_axis_tlast <= s00_axis_tlast.
  - acc <= 0; cnt <= 0.
- Early tlast: a partial window is still divided by N, not by the sample count. A partial mean is intentionally attenuated.
- Output drain: if m00_axis_tvalid && m00_axis_tready and no dump occurs in the same cycle, then m00_axis_tvalid <= 0 and m00_axis_tlast <= 0.
- Simultaneous drain and dump: the new value overwrites the old one and tvalid stays 1. There is no bubble.
- s00_axis_tready = ~reset && (~m00_axis_tvalid || m00_axis_tready). This is combinational. A full, stalled output register stalls all input, including non-dump samples.
- Reset (async assert): acc = 0, cnt = 0, m00_axis_tvalid = 0, m00_axis_tdata = 0, m00_axis_tlast = 0, s00_axis_tready = 0. m00_axis_tstrb stays all-ones. A partial window in progress is discarded.

## Timing
- Throughput: one input per cycle while unstalled; one output per N inputs, or fewer on tlast.
- Latency: m00_axis_tvalid rises on the clock edge that accepts the dumping sample. Data is visible the following cycle.
- Output holds its tdata and tlast stable while tvalid=1 and tready=0, per AXI-Stream.
- First accept after reset release: the first rising edge where reset is 0 and tvalid is 1.
- cnt wraps N-1 -> 0 only via dump; no other wrap exists.

## Test plan
- DECIM_LOG2=2; inputs 1,2,3,4; m00_axis_tready=1:
  - Exactly one output, tdata=0x00000003 ((10+2)>>>2), tlast=0.
  - tvalid is high for one cycle after the 4th accept.
- DECIM_LOG2=2; inputs -1,-1,-1,-2 (0xFFFF,0xFFFF,0xFFFF,0xFFFE):
  - ((-5+2)>>>2) gives tdata=0xFFFFFFFF.
- DECIM_LOG2=2; inputs 8, 8 with tlast on the second:
  - Output tdata=0x00000004 ((16+2)>>>2), m00_axis_tlast=1.
  - The next four samples of 4 give 0x00000004 with tlast=0.
- Backpressure:
  - Hold m00_axis_tready=0 after an output: s00_axis_tready=0, and tdata, tvalid and tlast stay stable for 10 cycles.
  - On release, the stream resumes with no sample lost or duplicated, checked against a reference model.
- Full scale, DECIM_LOG2=4:
  - 16 samples of 0x7FFF give 0x00007FFF.
  - 16 samples of 0x8000 give 0xFFFF8000.
- Reset mid-window, DECIM_LOG2=2:
  - Accept 100, 100, then pulse reset asynchronously, not aligned to the clock edge.
  - Outputs go to 0 immediately.
  - After release, 5,5,5,5 gives exactly 0x00000005.
